// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - MEM-stage data memory with sized accesses, faults and latency pipeline
//
// Purpose: DEPTH x 32-bit data memory for the MEM stage. After reset a
// hardware sequencer fills the array (INIT), then requests are accepted every
// cycle (RUN). Byte/half/word loads and stores, little-endian lanes,
// misalignment faults, and READ_LATENCY-deep in-order response pipeline.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     request present this cycle
//   req_ready     high in RUN (no backpressure), low during INIT
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 zero-extend, 0 sign-extend
//   req_addr      byte address (wraps modulo 4*DEPTH)
//   req_wdata     store data, right-justified
//   rsp_valid     one pulse per accepted request, in order
//   rsp_rdata     extended load data (0 for stores and faults)
//   rsp_fault     response belongs to a faulted request
module dmem_pipe #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 256,
  parameter int INIT_MODE    = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             accept;
  logic             fault;
  logic             do_store;
  logic [31:0]      rd_word;
  logic [15:0]      rd_shift;
  logic [31:0]      ld_data;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic [31:0]      init_word;
  logic             unused_addr;

  // Address bits above the word index are ignored so the array aliases.
  assign idx         = req_addr[IDX_W+1:2];
  assign off         = req_addr[1:0];
  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

  assign req_ready = (state_q == ST_RUN);
  assign accept    = req_valid && (state_q == ST_RUN);

  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = off[0];
      2'b10:   fault = (off != 2'b00);
      default: fault = 1'b1;
    endcase
  end

  assign do_store = accept && req_write && !fault;

  // Combinational read: a load one edge after a store sees the new data.
  assign rd_word  = mem_q[idx];
  assign rd_shift = 16'(rd_word >> {off, 3'b000});

  always_comb begin
    ld_data = 32'h0;
    if (!fault && !req_write) begin
      case (req_size)
        2'b00:   ld_data = {{24{rd_shift[7] & ~req_unsigned}}, rd_shift[7:0]};
        2'b01:   ld_data = {{16{rd_shift[15] & ~req_unsigned}}, rd_shift[15:0]};
        default: ld_data = rd_word;
      endcase
    end
  end

  // Replicate narrow data across lanes; the byte enables pick the lanes.
  always_comb begin
    wr_data = req_wdata;
    wr_be   = 4'hF;
    case (req_size)
      2'b00: begin
        wr_data = {4{req_wdata[7:0]}};
        wr_be   = 4'b0001 << off;
      end
      2'b01: begin
        wr_data = {2{req_wdata[15:0]}};
        wr_be   = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  assign init_word = (INIT_MODE == 1) ? {{(32-IDX_W){1'b0}}, init_ptr_q} : 32'h0;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + IDX_W'(1);
      if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // The array itself has no reset; INIT rewrites every word after rst.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_ptr_q] <= init_word;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures on acceptance. Data/fault only load
  // when a valid enters a stage, so the outputs hold while rsp_valid is low.
  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] flt_q;
  logic [31:0]             dat_q [READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      flt_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        dat_q[0] <= ld_data;
        flt_q[0] <= fault;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
          flt_q[k] <= flt_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[READ_LATENCY-1];
  assign rsp_rdata = dat_q[READ_LATENCY-1];
  assign rsp_fault = flt_q[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// tb/tb_dmem_pipe.sv - self-checking bench for dmem_pipe with a byte-array reference model
module tb_dmem_pipe;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          t;
    logic [31:0] d;
    logic        f;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t got_q[$];
  logic [7:0] mb [NB];

  dmem_pipe #(
    .ADDR_W(32),
    .DEPTH(DEPTH),
    .INIT_MODE(1),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Recorder only: every response seen is queued with the edge count.
  always @(negedge clk) begin
    if (rsp_valid) got_q.push_back('{t: cyc, d: rsp_rdata, f: rsp_fault});
  end

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < 4; k++)
        mb[4*i+k] = 8'(i >> (8*k));
  endfunction

  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic f);
    int n, base;
    longint v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[9:0]);
    f    = (sz == 2'd3) || ((base % n) != 0);
    rd   = 32'h0;
    v    = 0;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v = v | (longint'(mb[base+i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    rsp_t e;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    model(w, sz, u, a, wd, e.d, e.f);
    e.t = cyc;
    exp_q.push_back(e);
  endtask

  task automatic settle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int edges = 0;
    rst = 1'b1;
    #12;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    n_checks++; if (rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", rsp_fault); end
    @(negedge clk);
    rst = 1'b0;
    while (edges < 1000) begin
      @(posedge clk); edges++; #1;
      if (req_ready) break;
    end
    n_checks++; if (edges !== DEPTH) begin n_fail++; $display("FAIL init_edges got %0d exp %0d", edges, DEPTH); end
    model_init();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_init_wrap();
    got_q.delete(); exp_q.delete();
    drive(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    settle(LAT + 2);
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL init_wrap_count got %0d exp 2", got_q.size());
    end else begin
      n_checks++; if (got_q[0].d !== 32'h000000FF) begin n_fail++; $display("FAIL load_3fc got %h exp 000000ff", got_q[0].d); end
      n_checks++; if (got_q[1].d !== 32'h00000000) begin n_fail++; $display("FAIL load_400_wrap got %h exp 00000000", got_q[1].d); end
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] ex [7];
    ex = '{32'h0, 32'h0, 32'h1122AB44, 32'h0, 32'hFFFFBEEF, 32'h0000BEEF, 32'hFFFFFFAB};
    got_q.delete(); exp_q.delete();
    drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF);
    drive(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    drive(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    drive(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    settle(LAT + 2);
    n_checks++;
    if (got_q.size() != 7) begin
      n_fail++; $display("FAIL byte_half_count got %0d exp 7", got_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (got_q[i].d !== ex[i] || got_q[i].f !== 1'b0) begin
          n_fail++; $display("FAIL byte_half[%0d] got %h/%b exp %h/0", i, got_q[i].d, got_q[i].f, ex[i]);
        end
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] exd [5];
    logic        exf [5];
    exd = '{32'h0, 32'h0, 32'h00000008, 32'h0, 32'h0};
    exf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    got_q.delete(); exp_q.delete();
    drive(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 32'h21, 32'h00005555);
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    drive(1'b0, 2'd3, 1'b0, 32'h30, 32'h0);
    drive(1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF);
    settle(LAT + 2);
    n_checks++;
    if (got_q.size() != 5) begin
      n_fail++; $display("FAIL faults_count got %0d exp 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got_q[i].d !== exd[i] || got_q[i].f !== exf[i]) begin
          n_fail++; $display("FAIL faults[%0d] got %h/%b exp %h/%b", i, got_q[i].d, got_q[i].f, exd[i], exf[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd2, 1'b0, 32'(4*i), 32'h0);
    settle(LAT + 2);
    t0 = exp_q[0].t;
    n_checks++;
    if (got_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_count got %0d exp 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_q[i].d !== 32'(i) || got_q[i].t != t0 + LAT - 1 + i) begin
          n_fail++; $display("FAIL b2b[%0d] got %h@%0d exp %h@%0d", i, got_q[i].d, got_q[i].t, 32'(i), t0 + LAT - 1 + i);
        end
      end
    end
  endtask

  task automatic test_raw();
    got_q.delete(); exp_q.delete();
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    settle(LAT + 2);
    n_checks++;
    if (got_q.size() != 2) begin
      n_fail++; $display("FAIL raw_count got %0d exp 2", got_q.size());
    end else begin
      n_checks++; if (got_q[1].d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw got %h exp deadbeef", got_q[1].d); end
    end
  endtask

  task automatic test_random();
    int nmin;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = $urandom();
      if ($urandom_range(0, 1) == 0) a[9:6] = 4'h0;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
      drive(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
    end
    settle(LAT + 3);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].f !== exp_q[i].f || got_q[i].t != exp_q[i].t + LAT - 1) begin
        n_fail++;
        $display("FAIL rand[%0d] got %h/%b@%0d exp %h/%b@%0d", i, got_q[i].d, got_q[i].f, got_q[i].t,
                 exp_q[i].d, exp_q[i].f, exp_q[i].t + LAT - 1);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int edges = 0;
    got_q.delete(); exp_q.delete();
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
    settle(LAT + 2);
    got_q.delete(); exp_q.delete();
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", req_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    while (edges < 1000) begin
      @(posedge clk); edges++; #1;
      if (req_ready) break;
    end
    n_checks++; if (edges !== DEPTH) begin n_fail++; $display("FAIL midrst_edges got %0d exp %0d", edges, DEPTH); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL midrst_late_rsp got %0d exp 0", got_q.size()); end
    model_init();
    got_q.delete(); exp_q.delete();
    drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    settle(LAT + 2);
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_reload_count got %0d exp 1", got_q.size());
    end else begin
      n_checks++; if (got_q[0].d !== 32'h00000010) begin n_fail++; $display("FAIL midrst_reload got %h exp 00000010", got_q[0].d); end
    end
  endtask

  initial begin
    test_reset();
    test_init_wrap();
    test_byte_half();
    test_faults();
    test_back_to_back();
    test_raw();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
